// File: rtl/oqpsk_tx_sequencer.sv
// oqpsk_tx_sequencer: FIFO-buffered MSB-first bit serializer with EN strobe and preamble/payload/tail framing for the OQPSK modulator (optional preamble: OQPSK_SEQ_PREAMBLE_EN)
module oqpsk_tx_sequencer #(
    parameter int DIV_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TAIL_BITS  = 12
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [7:0]       frame_len,
    input  logic             start,
    input  logic [7:0]       wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic             busy,
    output logic             done,
    output logic             underrun,
    output logic             BitIn,
    output logic             EN
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, PRE, DATA, TAIL} state_t;

    state_t           state, nstate;
    logic [15:0]      cnt, ncnt;
    logic [DIV_W-1:0] div_q, div_cnt;
    logic [7:0]       len_q, sreg, byte_in;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [AW:0]      count;
    logic             fire, last, data_last, new_byte, nbit, pop, push, empty, full, accept;

    assign accept    = state == IDLE && start;
    assign data_last = cnt == 16'({len_q, 3'b000}) - 16'd1;
    assign last      = state == TAIL && cnt == 16'(TAIL_BITS - 1) && EN;
    assign fire      = state == IDLE ? start : (div_cnt == '0 && !last);
    assign empty     = count == '0;
    assign full      = count == (AW+1)'(FIFO_DEPTH);
    assign byte_in   = empty ? 8'h00 : mem[rd_ptr];
    assign wr_ready  = !full || pop;
    assign push      = wr_valid && wr_ready;

    // State register: advances by one bit position on every emitted bit, and leaves TAIL after its last bit
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (fire || last) begin
            state <= nstate;
            cnt   <= ncnt;
        end
    end

    // Next-state: position of the bit that would be emitted next (cnt is the bit index within the state)
    always_comb begin
        nstate = state;
        ncnt   = cnt + 16'd1;
        case (state)
            IDLE: begin
                ncnt = '0;
`ifdef OQPSK_SEQ_PREAMBLE_EN
                nstate = start ? PRE : IDLE;
`else
                nstate = start ? (frame_len != 8'd0 ? DATA : TAIL) : IDLE;
`endif
            end
`ifdef OQPSK_SEQ_PREAMBLE_EN
            PRE: if (cnt == 16'd15) begin
                nstate = len_q != 8'd0 ? DATA : TAIL;
                ncnt   = '0;
            end
`endif
            DATA: if (data_last) begin
                nstate = TAIL;
                ncnt   = '0;
            end
            TAIL: nstate = last ? IDLE : TAIL;
            default: nstate = IDLE;
        endcase
    end

    // Output decode: next serial bit, FIFO pop at byte boundaries (empty FIFO substitutes 0x00)
    always_comb begin
        new_byte = nstate == DATA && ncnt[2:0] == 3'd0;
        nbit     = nstate == PRE ? ~ncnt[0] : nstate == DATA ? (new_byte ? byte_in[7] : sreg[7]) : 1'b0;
        pop      = fire && new_byte && !empty;
    end

    // Registered outputs, rate divider, latched frame config and payload shift register
    always_ff @(posedge CLK) begin
        if (RST) begin
            EN       <= 1'b0;
            BitIn    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
            div_cnt  <= '0;
            div_q    <= '0;
            len_q    <= '0;
            sreg     <= '0;
        end else begin
            EN       <= fire;
            done     <= last;
            busy     <= fire ? 1'b1 : last ? 1'b0 : busy;
            underrun <= (accept ? 1'b0 : underrun) | (fire && new_byte && empty);
            if (fire) begin
                BitIn   <= nbit;
                div_cnt <= accept ? cfg_div : div_q;
            end else if (div_cnt != '0)
                div_cnt <= div_cnt - DIV_W'(1);
            if (accept) begin
                div_q <= cfg_div;
                len_q <= frame_len;
            end
            if (fire && nstate == DATA)
                sreg <= {new_byte ? byte_in[6:0] : sreg[6:0], 1'b0};
        end
    end

    // Payload FIFO: writes accepted in any state, a pop in the same cycle frees a slot when full
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_oqpsk_tx_sequencer.sv
// tb_oqpsk_tx_sequencer: scoreboard bench, frame bit streams predicted from the framing rules
module tb_oqpsk_tx_sequencer;
    localparam int TAIL  = 12;
    localparam int DEPTH = 4;

    logic       CLK = 0, RST = 1;
    logic [7:0] cfg_div = 0, frame_len = 0, wr_data = 0;
    logic       start = 0, wr_valid = 0;
    logic       wr_ready, busy, done, underrun, BitIn, EN;

    typedef struct {
        bit is_done;
        bit val;
        int at;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model_q[$];
    int         checks = 0, errors = 0, cyc = 0;
    logic       last_bit = 0;

    oqpsk_tx_sequencer #(.DIV_W(8), .FIFO_DEPTH(DEPTH), .TAIL_BITS(TAIL)) dut (
        .CLK(CLK), .RST(RST), .cfg_div(cfg_div), .frame_len(frame_len), .start(start),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .busy(busy),
        .done(done), .underrun(underrun), .BitIn(BitIn), .EN(EN)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: every EN or done pops the scoreboard; BitIn must hold between strobes
    always @(negedge CLK) begin : mon
        exp_t e;
        if (RST)
            last_bit = 0;
        else if (EN || done) begin
            if (sb.size() == 0)
                check("unexpected_out", EN | done, 0);
            else begin
                e = sb.pop_front();
                if (EN) begin
                    check("en_cycle", cyc, e.at);
                    check("en_not_done", int'(e.is_done), 0);
                    check("bit", BitIn, e.val);
                    check("busy_on_en", busy, 1);
                    last_bit = BitIn;
                end else begin
                    check("done_cycle", cyc, e.at);
                    check("done_expected", int'(e.is_done), 1);
                    check("underrun", underrun, e.val);
                    check("busy_at_done", busy, 0);
                end
            end
        end else
            check("bit_hold", BitIn, last_bit);
    end

    task automatic push_exp(input bit d, input bit v, input int at);
        exp_t e;
        e.is_done = d;
        e.val = v;
        e.at = at;
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the following negedge
    task automatic wr(input logic [7:0] d);
        wr_data = d;
        wr_valid = 1;
        check("wr_ready", wr_ready, model_q.size() < DEPTH);
        if (model_q.size() < DEPTH) model_q.push_back(d);
        @(negedge CLK);
        wr_valid = 0;
    endtask

    task automatic frame(input int d, input int len, input bit mid_start, input bit wait_end);
        int t, k;
        logic [7:0] b;
        bit ur;
        ur = 0;
        k = 0;
        t = cyc;
        start = 1;
        cfg_div = 8'(d);
        frame_len = 8'(len);
`ifdef OQPSK_SEQ_PREAMBLE_EN
        for (int i = 0; i < 16; i++) begin
            push_exp(0, ~i[0], t + 1 + k * (d + 1));
            k++;
        end
`endif
        for (int n = 0; n < len; n++) begin
            if (model_q.size() != 0) b = model_q.pop_front();
            else begin
                b = 8'h00;
                ur = 1;
            end
            for (int j = 7; j >= 0; j--) begin
                push_exp(0, b[j], t + 1 + k * (d + 1));
                k++;
            end
        end
        for (int i = 0; i < TAIL; i++) begin
            push_exp(0, 0, t + 1 + k * (d + 1));
            k++;
        end
        push_exp(1, ur, t + 2 + (k - 1) * (d + 1));
        @(negedge CLK);
        start = 0;
        cfg_div = 8'($urandom);
        frame_len = 8'($urandom);
        if (mid_start) begin
            repeat (3) @(negedge CLK);
            start = 1;
            @(negedge CLK);
            start = 0;
        end
        if (wait_end) begin
            for (int i = 0; i < 20000 && sb.size() != 0; i++) @(negedge CLK);
            check("frame_timeout", sb.size(), 0);
            @(negedge CLK);
        end
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_en", EN, 0);
        check("rst_bitin", BitIn, 0);
        check("rst_underrun", underrun, 0);
        check("rst_wr_ready", wr_ready, 1);
        RST = 0;
        @(negedge CLK);
        wr(8'hC5);
        frame(0, 1, 0, 1);
        wr(8'hFF);
        wr(8'h00);
        frame(3, 2, 0, 1);
        wr(8'hA5);
        frame(1, 2, 0, 1);
        for (int i = 1; i <= 5; i++) wr(8'(i));
        frame(0, 4, 0, 1);
        frame(2, 0, 1, 1);
        for (int f = 0; f < 25; f++) begin
            int nw;
            nw = $urandom_range(0, 5);
            for (int i = 0; i < nw; i++) wr(8'($urandom));
            frame($urandom_range(0, 4), $urandom_range(0, 5), 1'($urandom_range(0, 1)), 1);
        end
        wr(8'h11);
        wr(8'h22);
        wr(8'h33);
        frame(0, 3, 0, 0);
        repeat (19) @(negedge CLK);
        RST = 1;
        @(posedge CLK);
        #1;
        sb.delete();
        model_q.delete();
        @(negedge CLK);
        check("midrst_busy", busy, 0);
        check("midrst_en", EN, 0);
        check("midrst_bitin", BitIn, 0);
        check("midrst_wr_ready", wr_ready, 1);
        check("midrst_done", done, 0);
        check("midrst_underrun", underrun, 0);
        @(negedge CLK);
        RST = 0;
        repeat (5) @(negedge CLK);
        frame(1, 1, 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
